adxl345_spi_responder: RTL and testbench

- Synthesizable 3-wire SPI slave that emulates the ADXL345 G-sensor at the far end of the accelerometer SPI interface.
- Connects to the SoC's SCLK, CS_N and SDAT pins and returns register reads and accepts register writes.
- Serves X/Y/Z samples supplied on parallel ports and raises the G_SENSOR_INT line on new data.
- Used for hardware-in-loop and simulation testing of the accelerometer path without a physical sensor.

---
 rtl/adxl345_pkg.sv | 30 +++
 rtl/adxl345_spi_responder_if.sv | 19 +
 rtl/adxl345_spi_responder_spi_pin_sync.sv | 40 ++++
 rtl/adxl345_spi_responder.sv | 179 +++++++++++++++++
 tb/tb_adxl345_spi_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adxl345_pkg.sv
// Shared constants, FSM state type and address helpers for the ADXL345 SPI responder.
package adxl345_pkg;

  localparam logic [5:0] ADDR_DEVID      = 6'h00;
  localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE = 6'h30;
  localparam logic [5:0] ADDR_DATAX0     = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1     = 6'h37;
  localparam int         DATA_READY_BIT  = 7;
  localparam int         NUM_SAMPLE_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  // Axis data registers: 0x32..0x37.
  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

  // Registers owned by the sensor side; SPI writes to them are dropped.
  function automatic logic is_read_only(input logic [5:0] a);
    return (a == ADDR_DEVID) || (a == ADDR_INT_SOURCE) || is_data_addr(a);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_if.sv
// Pin-level bundle between the SoC accelerometer SPI master and the responder.
interface adxl345_spi_responder_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_sdat_in;
  logic spi_sdat_out;
  logic spi_sdat_oe;
  logic g_sensor_int;

  modport master (
    output spi_sclk, spi_cs_n, spi_sdat_in,
    input  spi_sdat_out, spi_sdat_oe, g_sensor_int
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_sdat_in,
    output spi_sdat_out, spi_sdat_oe, g_sensor_int
  );
endinterface

// File: rtl/adxl345_spi_responder_spi_pin_sync.sv
// Synchronizers for the asynchronous SPI pins plus edge detection on SCLK and CS_N.
// The flops carry no reset so that a reset taken mid-frame cannot fake a CS_N edge.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_sdat,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_cs_n_hi,
  output logic o_sdat
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdat_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  // Shift pins through the synchronizer chains and keep one extra tap for edge detect.
  always_ff @(posedge i_clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
    r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], i_sdat};
    r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
  end

  assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign o_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
  assign o_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
  assign o_cs_n_hi   = r_cs_prev;
  assign o_sdat      = r_sdat_sync[SYNC_STAGES-1];

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 emulation: 3-wire SPI slave (CPOL=1, CPHA=1) over a 64x8 register file,
// with parallel X/Y/Z sample capture and a DATA_READY interrupt.
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_VAL   = 8'hE5
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  adxl345_spi_responder_if.slave spi,
  input  logic signed [15:0]     sample_x,
  input  logic signed [15:0]     sample_y,
  input  logic signed [15:0]     sample_z,
  input  logic                   sample_valid
);

  logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_cs_hi, w_sdat;
  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift_in;
  logic [7:0]  r_tx;
  logic [5:0]  r_addr;
  logic        r_mb;
  logic        r_rd_hit;
  logic        r_sdat_out, r_sdat_oe, r_int;
  logic [7:0]  r_regs [64];
  logic        r_pend;
  logic [47:0] r_pend_data;

  logic [7:0]  w_rx_byte;
  logic [5:0]  w_next_addr;
  logic [5:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic [47:0] w_new_samples;
  logic [47:0] w_load_data;
  logic        w_load;
  logic        w_commit;
  logic        w_dr_clear;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (clk_clk),
    .i_sclk     (spi.spi_sclk),
    .i_cs_n     (spi.spi_cs_n),
    .i_sdat     (spi.spi_sdat_in),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall),
    .o_cs_n_hi  (w_cs_hi),
    .o_sdat     (w_sdat)
  );

  assign w_rx_byte     = {r_shift_in, w_sdat};
  assign w_next_addr   = r_addr + 6'd1;
  // Command end fetches the addressed byte; byte end in a burst fetches the next one.
  assign w_rd_addr     = (r_state == ST_CMD) ? w_rx_byte[5:0] : w_next_addr;
  assign w_rd_data     = r_regs[w_rd_addr];
  // Byte i of this word lands at DATAX0+i (little-endian X, then Y, then Z).
  assign w_new_samples = {sample_z, sample_y, sample_x};

  // Samples load directly while the bus is idle; otherwise they wait for CS_N rise,
  // with a strobe on the rise cycle itself taking precedence over the held copy.
  assign w_load      = (sample_valid & w_cs_hi) | (w_cs_rise & (r_pend | sample_valid));
  assign w_load_data = (sample_valid | ~w_cs_rise) ? w_new_samples : r_pend_data;
  assign w_commit    = w_sclk_rise & ~w_cs_rise & (r_state == ST_WDATA) &
                       (r_bit_cnt == 3'd7) & ~is_read_only(r_addr);
  assign w_dr_clear  = w_cs_rise & r_rd_hit;

  // Register file: SPI writes, DATA_READY clear, then sample load (set wins over clear).
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++) r_regs[6'(i)] <= 8'h00;
      r_regs[ADDR_DEVID] <= DEVID_VAL;
    end else begin
      if (w_commit) r_regs[r_addr] <= w_rx_byte;
      if (w_dr_clear) r_regs[ADDR_INT_SOURCE][DATA_READY_BIT] <= 1'b0;
      if (w_load) begin
        for (int i = 0; i < NUM_SAMPLE_BYTES; i++)
          r_regs[ADDR_DATAX0 + 6'(i)] <= w_load_data[8*i +: 8];
        r_regs[ADDR_INT_SOURCE][DATA_READY_BIT] <= 1'b1;
      end
    end
  end

  // Held copy of samples that arrived during a transaction; newest strobe overwrites.
  always_ff @(posedge clk_clk) begin
    if (sample_valid & ~w_cs_hi) r_pend_data <= w_new_samples;
  end

  // SPI transaction FSM; CS_N rise overrides any SCLK edge seen on the same cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift_in <= 7'd0;
      r_tx       <= 8'h00;
      r_addr     <= 6'd0;
      r_mb       <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_sdat_out <= 1'b0;
      r_sdat_oe  <= 1'b0;
      r_pend     <= 1'b0;
    end else if (w_cs_rise) begin
      r_state    <= ST_IDLE;
      r_sdat_out <= 1'b0;
      r_sdat_oe  <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      if (sample_valid & ~w_cs_hi) r_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ST_CMD;
            r_bit_cnt <= 3'd0;
            r_rd_hit  <= 1'b0;
          end
        end
        ST_CMD: begin
          if (w_sclk_rise) begin
            r_shift_in <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr  <= w_rx_byte[5:0];
              r_mb    <= w_rx_byte[6];
              r_tx    <= w_rd_data;
              r_state <= w_rx_byte[7] ? ST_RDATA : ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (w_sclk_rise) begin
            r_shift_in <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_mb) r_addr <= w_next_addr;
              else      r_state <= ST_IGNORE;
            end
          end
        end
        ST_RDATA: begin
          if (w_sclk_fall) begin
            r_sdat_out <= r_tx[7];
            r_sdat_oe  <= 1'b1;
            r_tx       <= {r_tx[6:0], 1'b0};
            // A byte counts as returned once its first bit goes out.
            if (r_bit_cnt == 3'd0) r_rd_hit <= r_rd_hit | is_data_addr(r_addr);
          end else if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_mb) begin
                r_addr <= w_next_addr;
                r_tx   <= w_rd_data;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
        end
        ST_IGNORE: begin
          if (w_sclk_fall) r_sdat_oe <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Interrupt is DATA_READY gated by its enable bit, one register stage behind.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_int <= 1'b0;
    else r_int <= r_regs[ADDR_INT_SOURCE][DATA_READY_BIT] & r_regs[ADDR_INT_ENABLE][DATA_READY_BIT];
  end

  assign spi.spi_sdat_out = r_sdat_out;
  assign spi.spi_sdat_oe  = r_sdat_oe;
  assign spi.g_sensor_int = r_int;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Bench for adxl345_spi_responder: bit-level SPI master plus a register-map reference model.
module tb_adxl345_spi_responder;
  import adxl345_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;   // clk cycles per SCLK half period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] sx = '0, sy = '0, sz = '0;
  logic sv = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  adxl345_spi_responder_if spi_if();

  adxl345_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .DEVID_VAL(8'hE5)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .spi          (spi_if),
    .sample_x     (sx),
    .sample_y     (sy),
    .sample_z     (sz),
    .sample_valid (sv)
  );

  always #5 clk = ~clk;

  // ---------------- reference model of the register map ----------------
  logic [7:0]  m_reg [64];
  bit          m_dr;
  bit          m_pend;
  logic [15:0] m_px, m_py, m_pz;

  function automatic bit m_ro(input int a);
    return (a == 0) || (a == 48) || (a >= 50 && a <= 55);
  endfunction

  function automatic logic [7:0] m_get(input int a);
    return (a == 48) ? {m_dr, 7'd0} : m_reg[a];
  endfunction

  function automatic bit m_int();
    return m_dr & m_reg[46][7];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[0] = 8'hE5;
    m_dr = 0;
    m_pend = 0;
  endtask

  task automatic m_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_reg[50] = x[7:0]; m_reg[51] = x[15:8];
    m_reg[52] = y[7:0]; m_reg[53] = y[15:8];
    m_reg[54] = z[7:0]; m_reg[55] = z[15:8];
    m_dr = 1;
  endtask

  // ---------------- SPI master ----------------
  bit         mosi[$];
  bit         miso[$];
  int         oe_hi;
  bit         busy;
  logic [7:0] wq[$];
  logic [7:0] rq[$];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives mosi bit by bit: change on SCLK fall, master samples just before SCLK rise.
  task automatic spi_frame();
    busy = 1;
    miso.delete();
    oe_hi = 0;
    @(negedge clk);
    spi_if.spi_cs_n = 1'b0;
    idle(HALF);
    foreach (mosi[i]) begin
      spi_if.spi_sclk = 1'b0;
      spi_if.spi_sdat_in = mosi[i];
      idle(HALF);
      miso.push_back(spi_if.spi_sdat_out);
      if (spi_if.spi_sdat_oe) oe_hi++;
      spi_if.spi_sclk = 1'b1;
      idle(HALF);
    end
    spi_if.spi_cs_n = 1'b1;
    busy = 0;
  endtask

  task automatic spi_rw(input bit rd, input bit mb, input logic [5:0] a, input int n);
    logic [7:0] c;
    c = {rd, mb, a};
    mosi.delete();
    for (int b = 7; b >= 0; b--) mosi.push_back(c[b]);
    for (int k = 0; k < n; k++) begin
      logic [7:0] d;
      d = rd ? 8'h00 : wq[k];
      for (int b = 7; b >= 0; b--) mosi.push_back(d[b]);
    end
    spi_frame();
    rq.delete();
    for (int k = 0; k < n; k++) begin
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[7-b] = miso[8 + 8*k + b];
      rq.push_back(r);
    end
  endtask

  // Model effect of a completed frame: writes, DATA_READY clear, then held samples.
  task automatic m_frame_end(input bit rd, input int a, input int n);
    bit hit;
    hit = 0;
    for (int k = 0; k < n; k++) begin
      int ad;
      ad = (a + k) % 64;
      if (rd) begin
        if (ad >= 50 && ad <= 55) hit = 1;
      end else if (!m_ro(ad)) begin
        m_reg[ad] = wq[k];
      end
    end
    if (hit) m_dr = 0;
    if (m_pend) begin
      m_load(m_px, m_py, m_pz);
      m_pend = 0;
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sx = x; sy = y; sz = z; sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_tests++;
    if (spi_if.spi_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", spi_if.spi_sdat_oe); end
    n_tests++;
    if (spi_if.spi_sdat_out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", spi_if.spi_sdat_out); end
    n_tests++;
    if (spi_if.g_sensor_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", spi_if.g_sensor_int); end
  endtask

  task automatic test_devid();
    spi_rw(1, 0, 6'h00, 1);
    n_tests++;
    if (rq[0] !== 8'hE5) begin n_fail++; $display("FAIL devid_read: got %h expected e5", rq[0]); end
    n_tests++;
    if (oe_hi != 8) begin n_fail++; $display("FAIL devid_oe_bits: got %0d expected 8", oe_hi); end
    m_frame_end(1, 0, 1);
    idle(2*HALF);
    n_tests++;
    if (spi_if.spi_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL devid_oe_after: got %b expected 0", spi_if.spi_sdat_oe); end
  endtask

  task automatic test_write_read();
    wq = '{8'h08};
    spi_rw(0, 0, 6'h2D, 1); m_frame_end(0, 45, 1); idle(2*HALF);
    spi_rw(1, 0, 6'h2D, 1);
    n_tests++;
    if (rq[0] !== 8'h08) begin n_fail++; $display("FAIL wr_rd_2d: got %h expected 08", rq[0]); end
    m_frame_end(1, 45, 1); idle(2*HALF);
    wq = '{8'h11};
    spi_rw(0, 0, 6'h00, 1); m_frame_end(0, 0, 1); idle(2*HALF);
    spi_rw(1, 0, 6'h00, 1);
    n_tests++;
    if (rq[0] !== 8'hE5) begin n_fail++; $display("FAIL ro_devid: got %h expected e5", rq[0]); end
    m_frame_end(1, 0, 1); idle(2*HALF);
  endtask

  task automatic test_random_rw();
    for (int it = 0; it < 8; it++) begin
      int a;
      logic [7:0] d, e0, e1;
      a = int'($urandom_range(0, 63));
      d = 8'($urandom_range(0, 255));
      wq = '{d};
      spi_rw(0, 0, 6'(a), 1); m_frame_end(0, a, 1); idle(2*HALF);
      e0 = m_get(a);
      e1 = m_get((a + 1) % 64);
      spi_rw(1, 1, 6'(a), 2);
      n_tests++;
      if (rq[0] !== e0) begin n_fail++; $display("FAIL rand_rd0 addr=%h: got %h expected %h", a, rq[0], e0); end
      n_tests++;
      if (rq[1] !== e1) begin n_fail++; $display("FAIL rand_rd1 addr=%h: got %h expected %h", a, rq[1], e1); end
      m_frame_end(1, a, 2); idle(2*HALF);
    end
  endtask

  task automatic test_samples();
    logic [7:0] exp6 [6];
    int k;
    exp6 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F};
    wq = '{8'h80};
    spi_rw(0, 0, 6'h2E, 1); m_frame_end(0, 46, 1); idle(2*HALF);
    pulse_sample(16'h1234, 16'hABCD, 16'h0F0F);
    m_load(16'h1234, 16'hABCD, 16'h0F0F);
    idle(3);
    n_tests++;
    if (spi_if.g_sensor_int !== m_int()) begin n_fail++; $display("FAIL int_set: got %b expected %b", spi_if.g_sensor_int, m_int()); end
    spi_rw(1, 1, 6'h32, 6);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (rq[i] !== exp6[i]) begin n_fail++; $display("FAIL sample_byte%0d: got %h expected %h", i, rq[i], exp6[i]); end
    end
    k = 0;
    while (k < 12) begin
      @(negedge clk);
      k++;
      if (spi_if.g_sensor_int === 1'b0) break;
    end
    n_tests++;
    if (k != SYNC_STAGES + 2) begin n_fail++; $display("FAIL int_fall_latency: got %0d cycles expected %0d", k, SYNC_STAGES + 2); end
    m_frame_end(1, 50, 6); idle(2*HALF);
  endtask

  task automatic test_sample_midread();
    logic [7:0]  old [6];
    logic [15:0] ny, nz;
    ny = 16'($urandom); nz = 16'($urandom);
    for (int i = 0; i < 6; i++) old[i] = m_get(50 + i);
    fork
      spi_rw(1, 1, 6'h32, 6);
      begin
        idle(HALF + 20*2*HALF);
        pulse_sample(16'h5555, ny, nz);
      end
    join
    m_pend = 1; m_px = 16'h5555; m_py = ny; m_pz = nz;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (rq[i] !== old[i]) begin n_fail++; $display("FAIL midread_old%0d: got %h expected %h", i, rq[i], old[i]); end
    end
    m_frame_end(1, 50, 6); idle(2*HALF);
    spi_rw(1, 0, 6'h30, 1);
    n_tests++;
    if (rq[0] !== m_get(48)) begin n_fail++; $display("FAIL midread_int_source: got %h expected %h", rq[0], m_get(48)); end
    m_frame_end(1, 48, 1); idle(2*HALF);
    n_tests++;
    if (spi_if.g_sensor_int !== m_int()) begin n_fail++; $display("FAIL midread_int: got %b expected %b", spi_if.g_sensor_int, m_int()); end
    spi_rw(1, 1, 6'h32, 6);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (rq[i] !== m_get(50 + i)) begin n_fail++; $display("FAIL midread_new%0d: got %h expected %h", i, rq[i], m_get(50 + i)); end
    end
    m_frame_end(1, 50, 6); idle(2*HALF);
  endtask

  task automatic test_partial_write();
    logic [7:0] old, c, d;
    old = m_reg[45];
    d = ~old;
    c = {1'b0, 1'b0, 6'h2D};
    mosi.delete();
    for (int b = 7; b >= 0; b--) mosi.push_back(c[b]);
    for (int b = 7; b >= 4; b--) mosi.push_back(d[b]);
    spi_frame();
    idle(2*HALF);
    n_tests++;
    if (spi_if.spi_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL partial_oe: got %b expected 0", spi_if.spi_sdat_oe); end
    n_tests++;
    if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL partial_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
    spi_rw(1, 0, 6'h2D, 1);
    n_tests++;
    if (rq[0] !== old) begin n_fail++; $display("FAIL partial_reg: got %h expected %h", rq[0], old); end
    m_frame_end(1, 45, 1); idle(2*HALF);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    wq = '{d};
    spi_rw(0, 0, 6'h3F, 1); m_frame_end(0, 63, 1); idle(2*HALF);
    spi_rw(1, 1, 6'h3F, 2);
    n_tests++;
    if (rq[0] !== m_get(63)) begin n_fail++; $display("FAIL wrap_3f: got %h expected %h", rq[0], m_get(63)); end
    n_tests++;
    if (rq[1] !== 8'hE5) begin n_fail++; $display("FAIL wrap_00: got %h expected e5", rq[1]); end
    m_frame_end(1, 63, 2); idle(2*HALF);
  endtask

  task automatic test_reset_midframe();
    int post_oe, guard;
    wq = '{8'h5A};
    spi_rw(0, 0, 6'h2D, 1); m_frame_end(0, 45, 1); idle(2*HALF);
    post_oe = 0; guard = 0;
    fork
      spi_rw(1, 0, 6'h00, 1);
      begin
        idle(HALF + 11*2*HALF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (spi_if.spi_sdat_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b expected 0", spi_if.spi_sdat_oe); end
        while (busy && guard < 2000) begin
          @(negedge clk);
          guard++;
          if (spi_if.spi_sdat_oe) post_oe++;
        end
      end
    join
    m_reset();
    n_tests++;
    if (post_oe != 0) begin n_fail++; $display("FAIL rstmid_ignore: got %0d oe cycles expected 0", post_oe); end
    idle(2*HALF);
    spi_rw(1, 0, 6'h2D, 1);
    n_tests++;
    if (rq[0] !== m_get(45)) begin n_fail++; $display("FAIL rstmid_regfile: got %h expected %h", rq[0], m_get(45)); end
    m_frame_end(1, 45, 1); idle(2*HALF);
    spi_rw(1, 0, 6'h00, 1);
    n_tests++;
    if (rq[0] !== 8'hE5) begin n_fail++; $display("FAIL rstmid_devid: got %h expected e5", rq[0]); end
    m_frame_end(1, 0, 1); idle(2*HALF);
  endtask

  initial begin
    spi_if.spi_sclk = 1'b1;
    spi_if.spi_cs_n = 1'b1;
    spi_if.spi_sdat_in = 1'b0;
    m_reset();
    rst_n = 1'b0;
    idle(10);
    rst_n = 1'b1;
    idle(2);
    test_reset();
    test_devid();
    test_write_read();
    test_random_rw();
    test_samples();
    test_sample_midread();
    test_partial_write();
    test_wrap();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
